// File: rtl/control_seq.sv
// control_seq: eight-phase instruction sequencer for the VeriRISC datapath.
// It steps INST_ADDR..STORE and decodes the live opcode into datapath strobes.
// It also provides memory wait states (fixed count plus an optional ready
// handshake), a latched halt with resume, single-step pausing and a counter
// of retired instructions.
//
// Ports
//   clk, rst_        rising-edge clock; synchronous active-high reset
//   opcode           current IR opcode (typedefs_pkg::opcode_t)
//   zero             accumulator zero flag (used by SKZ)
//   mem_ready        memory read data valid (only when USE_READY=1)
//   resume           leave the halted condition
//   step_en, step    single-step enable / release one instruction
//   load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt   strobes
//   phase            current phase, INST_ADDR=0 .. STORE=7
//   instr_done       one-cycle pulse in the cycle STORE advances
//   instr_cnt        retired instruction count, wraps

package typedefs_pkg;
  typedef enum logic [2:0] {
    HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
    XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7
  } opcode_t;
endpackage

module control_seq
  import typedefs_pkg::*;
#(
  parameter int unsigned MEM_WAIT  = 0,
  parameter bit          USE_READY = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  opcode_t          opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             resume,
  input  logic             step_en,
  input  logic             step,
  output logic             load_ac,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             load_ir,
  output logic             halt,
  output logic [2:0]       phase,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  localparam int unsigned    WAIT_W    = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT);

  logic              halted;
  logic              paused;
  logic [WAIT_W-1:0] wait_cnt;

  logic       alu_op;
  logic       stall_phase;
  logic       wait_hold;
  logic       pause_hold;
  logic [2:0] next_phase;
  logic       load_wait;

  always_comb begin
    alu_op      = (opcode == ADD) || (opcode == AND) ||
                  (opcode == XOR) || (opcode == LDA);
    stall_phase = (phase == INST_FETCH) || ((phase == OP_FETCH) && alu_op);
    wait_hold   = stall_phase &&
                  ((wait_cnt != '0) || (USE_READY && !mem_ready));
    // A pause only holds while step_en is still set; dropping step_en lets
    // the pending pause fall through and be cleared by the advance below.
    pause_hold  = (phase == INST_ADDR) && paused && step_en && !step;
    next_phase  = phase + 3'd1;
    load_wait   = (next_phase == INST_FETCH) ||
                  ((next_phase == OP_FETCH) && alu_op);
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      phase     <= INST_ADDR;
      halted    <= 1'b0;
      paused    <= 1'b0;
      wait_cnt  <= '0;
      instr_cnt <= '0;
    end else if (halted) begin
      if (resume) begin
        halted <= 1'b0;
        phase  <= OP_FETCH;
        if (alu_op) wait_cnt <= WAIT_LOAD;
      end
    end else if ((phase == OP_ADDR) && (opcode == HLT)) begin
      halted <= 1'b1;
    end else if (!pause_hold) begin
      if (wait_hold) begin
        if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
      end else begin
        phase  <= next_phase;
        paused <= 1'b0;
        if (load_wait) wait_cnt <= WAIT_LOAD;
        if (phase == STORE) begin
          instr_cnt <= instr_cnt + 1'b1;
          paused    <= step_en;
        end
      end
    end
  end

  always_comb begin
    load_ac    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    inc_pc     = 1'b0;
    load_pc    = 1'b0;
    load_ir    = 1'b0;
    halt       = 1'b0;
    instr_done = 1'b0;
    case (phase)
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (opcode == HLT);
      end
      OP_FETCH: mem_rd = alu_op;
      ALU_OP: begin
        load_ac = alu_op;
        mem_rd  = alu_op;
        inc_pc  = (opcode == SKZ) && zero;
        load_pc = (opcode == JMP);
      end
      STORE: begin
        load_ac    = alu_op;
        mem_rd     = alu_op;
        inc_pc     = (opcode == JMP);
        load_pc    = (opcode == JMP);
        mem_wr     = (opcode == STO);
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (halted) begin
      load_ac    = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      inc_pc     = 1'b0;
      load_pc    = 1'b0;
      load_ir    = 1'b0;
      halt       = 1'b1;
      instr_done = 1'b0;
    end
    if (rst_) begin
      load_ac    = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      inc_pc     = 1'b0;
      load_pc    = 1'b0;
      load_ir    = 1'b0;
      halt       = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq: three instances (defaults, wait
// states with ready handshake, narrow counter) share one stimulus set.
module tb_control_seq;
  import typedefs_pkg::*;

  localparam int unsigned WB = 2;

  logic    clk;
  logic    rst_;
  opcode_t opcode;
  logic    zero, mem_ready, resume, step_en, step;

  logic a_load_ac, a_mem_rd, a_mem_wr, a_inc_pc, a_load_pc, a_load_ir, a_halt;
  logic [2:0] a_phase;
  logic a_done;
  logic [15:0] a_cnt;

  logic b_load_ac, b_mem_rd, b_mem_wr, b_inc_pc, b_load_pc, b_load_ir, b_halt;
  logic [2:0] b_phase;
  logic b_done;
  logic [15:0] b_cnt;

  logic c_load_ac, c_mem_rd, c_mem_wr, c_inc_pc, c_load_pc, c_load_ir, c_halt;
  logic [2:0] c_phase;
  logic c_done;
  logic [1:0] c_cnt;

  logic [6:0] a_str, b_str;
  assign a_str = {a_load_ac, a_mem_rd, a_mem_wr, a_inc_pc, a_load_pc, a_load_ir, a_halt};
  assign b_str = {b_load_ac, b_mem_rd, b_mem_wr, b_inc_pc, b_load_pc, b_load_ir, b_halt};

  int checks   = 0;
  int failures = 0;

  control_seq dut0 (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .step_en(step_en), .step(step),
    .load_ac(a_load_ac), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .inc_pc(a_inc_pc),
    .load_pc(a_load_pc), .load_ir(a_load_ir), .halt(a_halt),
    .phase(a_phase), .instr_done(a_done), .instr_cnt(a_cnt)
  );

  control_seq #(.MEM_WAIT(WB), .USE_READY(1'b1)) dut1 (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .step_en(step_en), .step(step),
    .load_ac(b_load_ac), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .inc_pc(b_inc_pc),
    .load_pc(b_load_pc), .load_ir(b_load_ir), .halt(b_halt),
    .phase(b_phase), .instr_done(b_done), .instr_cnt(b_cnt)
  );

  control_seq #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .step_en(step_en), .step(step),
    .load_ac(c_load_ac), .mem_rd(c_mem_rd), .mem_wr(c_mem_wr), .inc_pc(c_inc_pc),
    .load_pc(c_load_pc), .load_ir(c_load_ir), .halt(c_halt),
    .phase(c_phase), .instr_done(c_done), .instr_cnt(c_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Expected strobes {load_ac,mem_rd,mem_wr,inc_pc,load_pc,load_ir,halt}
  function automatic logic [6:0] exp_str(int ph, opcode_t op, bit z, bit hlt);
    logic [6:0] s;
    bit alu;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    s = '0;
    if (hlt) return 7'b0000001;
    s[6] = (ph >= 6) && alu;
    s[5] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    s[4] = (ph == 7) && (op == STO);
    s[3] = (ph == 4) || (ph == 6 && op == SKZ && z) || (ph == 7 && op == JMP);
    s[2] = (ph >= 6) && (op == JMP);
    s[1] = (ph == 2) || (ph == 3);
    s[0] = (ph == 4) && (op == HLT);
    return s;
  endfunction

  function automatic bit is_alu(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b1; step_en = 1'b0; step = 1'b0; resume = 1'b0; mem_ready = 1'b1;
    tick();
    rst_ = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b1; opcode = LDA; zero = 1'b0; mem_ready = 1'b1;
    resume = 1'b0; step_en = 1'b0; step = 1'b0;
    tick(); tick();
    @(negedge clk);
    checks++; if (a_phase !== 3'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", a_phase); end
    checks++; if (a_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
    checks++; if (a_str !== 7'd0 || a_done !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b/%b exp=0000000/0", a_str, a_done); end
    checks++; if (b_phase !== 3'd0 || b_cnt !== 16'd0) begin failures++; $display("FAIL reset_wait_dut got=%0d/%0d exp=0/0", b_phase, b_cnt); end
    tick();
    rst_ = 1'b0;
  endtask

  task automatic test_decode();
    opcode_t ops[4] = '{LDA, JMP, SKZ, SKZ};
    bit      zs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int n = 0; n < 12; n++) begin
      opcode_t op;
      bit z;
      if (n < 4) begin
        op = ops[n]; z = zs[n];
      end else begin
        op = opcode_t'($urandom_range(7, 1));
        z  = 1'($urandom_range(1, 0));
      end
      opcode = op; zero = z;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (k == 0) begin
          checks++; if (a_cnt !== 16'(n)) begin failures++; $display("FAIL decode_cnt n=%0d got=%0d exp=%0d", n, a_cnt, n); end
          checks++; if (c_cnt !== 2'(n % 4)) begin failures++; $display("FAIL decode_cnt_wrap n=%0d got=%0d exp=%0d", n, c_cnt, n % 4); end
        end
        checks++; if (a_phase !== 3'(k)) begin failures++; $display("FAIL decode_phase n=%0d got=%0d exp=%0d", n, a_phase, k); end
        checks++; if (a_str !== exp_str(k, op, z, 1'b0)) begin failures++; $display("FAIL decode_strobes n=%0d op=%s z=%0d ph=%0d got=%b exp=%b", n, op.name(), z, k, a_str, exp_str(k, op, z, 1'b0)); end
        checks++; if (a_done !== (k == 7)) begin failures++; $display("FAIL decode_done n=%0d ph=%0d got=%b exp=%b", n, k, a_done, (k == 7)); end
        tick();
      end
    end
    @(negedge clk);
    checks++; if (a_cnt !== 16'd12 || c_cnt !== 2'd0) begin failures++; $display("FAIL decode_cnt_final got=%0d/%0d exp=12/0", a_cnt, c_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    opcode = HLT; zero = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (a_phase !== 3'(k) || a_str !== exp_str(k, HLT, 1'b0, 1'b0)) begin failures++; $display("FAIL halt_lead ph=%0d got=%0d/%b exp=%0d/%b", k, a_phase, a_str, k, exp_str(k, HLT, 1'b0, 1'b0)); end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (a_phase !== 3'd4 || a_str !== 7'b0000001) begin failures++; $display("FAIL halt_hold i=%0d got=%0d/%b exp=4/0000001", i, a_phase, a_str); end
      if (i == 4) begin resume = 1'b1; step = 1'b1; end
      tick();
    end
    resume = 1'b0; step = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      checks++; if (a_phase !== 3'(k) || a_str !== exp_str(k, HLT, 1'b0, 1'b0)) begin failures++; $display("FAIL halt_resume ph=%0d got=%0d/%b exp=%0d/%b", k, a_phase, a_str, k, exp_str(k, HLT, 1'b0, 1'b0)); end
      checks++; if (a_done !== (k == 7)) begin failures++; $display("FAIL halt_done ph=%0d got=%b exp=%b", k, a_done, (k == 7)); end
      tick();
    end
    @(negedge clk);
    checks++; if (a_phase !== 3'd0 || a_cnt !== 16'd1) begin failures++; $display("FAIL halt_retire got=%0d/%0d exp=0/1", a_phase, a_cnt); end
  endtask

  task automatic test_step();
    do_reset();
    step_en = 1'b1; opcode = STO; zero = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (a_phase !== 3'(k) || a_str !== exp_str(k, STO, 1'b0, 1'b0)) begin failures++; $display("FAIL step_instr ph=%0d got=%0d/%b exp=%0d/%b", k, a_phase, a_str, k, exp_str(k, STO, 1'b0, 1'b0)); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (a_phase !== 3'd0 || a_str !== 7'd0 || a_done !== 1'b0) begin failures++; $display("FAIL step_pause i=%0d got=%0d/%b exp=0/0000000", i, a_phase, a_str); end
      tick();
    end
    step = 1'b1;
    @(negedge clk);
    checks++; if (a_phase !== 3'd0) begin failures++; $display("FAIL step_release_pre got=%0d exp=0", a_phase); end
    tick();
    step = 1'b0; step_en = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      checks++; if (a_phase !== 3'(k)) begin failures++; $display("FAIL step_run ph got=%0d exp=%0d", a_phase, k); end
      tick();
    end
    @(negedge clk);
    checks++; if (a_phase !== 3'd0 || a_cnt !== 16'd2) begin failures++; $display("FAIL step_wrap got=%0d/%0d exp=0/2", a_phase, a_cnt); end
    tick();
    @(negedge clk);
    checks++; if (a_phase !== 3'd1) begin failures++; $display("FAIL step_nopause got=%0d exp=1", a_phase); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    opcode = ADD; zero = 1'b0;
    repeat (30) tick();
    @(negedge clk);
    checks++; if (a_phase !== 3'd6 || a_cnt !== 16'd3) begin failures++; $display("FAIL rstmid_pre got=%0d/%0d exp=6/3", a_phase, a_cnt); end
    checks++; if (a_str !== exp_str(6, ADD, 1'b0, 1'b0)) begin failures++; $display("FAIL rstmid_pre_str got=%b exp=%b", a_str, exp_str(6, ADD, 1'b0, 1'b0)); end
    rst_ = 1'b1;
    #1;
    checks++; if (a_str !== 7'd0 || a_done !== 1'b0) begin failures++; $display("FAIL rstmid_gated got=%b/%b exp=0000000/0", a_str, a_done); end
    tick();
    rst_ = 1'b0;
    @(negedge clk);
    checks++; if (a_phase !== 3'd0 || a_cnt !== 16'd0 || a_str !== 7'd0 || a_done !== 1'b0) begin failures++; $display("FAIL rstmid_post got=%0d/%0d/%b/%b exp=0/0/0000000/0", a_phase, a_cnt, a_str, a_done); end
  endtask

  task automatic test_wait();
    int seen;
    do_reset();
    opcode = LDA; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (b_phase !== 3'd0) begin failures++; $display("FAIL wait_start got=%0d exp=0", b_phase); end
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) mem_ready = 1'b1;
      @(negedge clk);
      checks++; if (b_phase !== 3'd1 || b_mem_rd !== 1'b1) begin failures++; $display("FAIL wait_hold i=%0d got=%0d/%b exp=1/1", i, b_phase, b_mem_rd); end
      tick();
    end
    @(negedge clk);
    checks++; if (b_phase !== 3'd2) begin failures++; $display("FAIL wait_release got=%0d exp=2", b_phase); end
    seen = -1;
    for (int i = 7; i < 30; i++) begin
      if (b_done === 1'b1 && seen < 0) seen = i;
      tick();
      @(negedge clk);
    end
    checks++; if (seen != 12 + int'(WB)) begin failures++; $display("FAIL wait_done_cycle got=%0d exp=%0d", seen, 12 + int'(WB)); end
  endtask

  task automatic test_wait_random();
    int mph, el, ninstr;
    opcode_t op;
    bit z;
    do_reset();
    mph = 0; el = 0; ninstr = 0; op = LDA; z = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (mph == 0) begin
        op = opcode_t'($urandom_range(7, 1));
        z  = 1'($urandom_range(1, 0));
      end
      opcode = op; zero = z;
      mem_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      checks++; if (b_phase !== 3'(mph)) begin failures++; $display("FAIL wrand_phase c=%0d got=%0d exp=%0d", c, b_phase, mph); end
      checks++; if (b_str !== exp_str(mph, op, z, 1'b0) || b_done !== (mph == 7)) begin failures++; $display("FAIL wrand_strobes c=%0d op=%s ph=%0d got=%b/%b exp=%b/%b", c, op.name(), mph, b_str, b_done, exp_str(mph, op, z, 1'b0), (mph == 7)); end
      // A stalling phase is left once MEM_WAIT cycles have elapsed in it and ready is seen.
      if ((mph == 1 || (mph == 5 && is_alu(op))) && (el < int'(WB) || !mem_ready)) begin
        el++;
      end else begin
        el = 0;
        if (mph == 7) ninstr++;
        mph = (mph + 1) % 8;
      end
      tick();
    end
    @(negedge clk);
    checks++; if (b_cnt !== 16'(ninstr)) begin failures++; $display("FAIL wrand_cnt got=%0d exp=%0d", b_cnt, ninstr); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_halt();
    test_step();
    test_reset_mid();
    test_wait();
    test_wait_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
